// File: rtl/pr_bus_pkg.sv
// Shared types and constants for the processor-side peripheral bus arbiter.
// FSM states, master identifiers, bridge device windows and the latched request bundle.
package pr_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Address windows decoded by the Bridge behind this arbiter.
  localparam logic [31:0] DEV0_LO = 32'h0000_7f00;
  localparam logic [31:0] DEV0_HI = 32'h0000_7f0b;
  localparam logic [31:0] DEV1_LO = 32'h0000_7f10;
  localparam logic [31:0] DEV1_HI = 32'h0000_7f1b;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
  } bus_req_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pr_arb_pick.sv
// Combinational winner select for the two bus masters.
// Round-robin alternates on ties; fixed priority favours M0 unless M1 has starved.
import pr_bus_pkg::*;

module pr_arb_pick #(
  parameter bit RR_MODE  = 1'b0,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic [1:0]       req_i,
  input  master_e          last_grant_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output master_e          grant_o,
  output logic             valid_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    grant_o = M0;
    valid_o = |req_i;
    case (req_i)
      2'b01: grant_o = M0;
      2'b10: grant_o = M1;
      2'b11: begin
        if (RR_MODE) begin
          grant_o = (last_grant_i == M0) ? M1 : M0;
        end else begin
          grant_o = (starve_cnt_i == CNT_W'(MAX_WAIT)) ? M1 : M0;
        end
      end
      default: grant_o = M0;
    endcase
  end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master arbiter in front of the Bridge: one transaction in flight,
// IDLE -> XFER -> RESP, registered bus drive and a one-cycle ack back to the owner.
import pr_bus_pkg::*;

module pr_bus_arbiter #(
  parameter bit RR_MODE  = 1'b0,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wd,
  output logic [31:0] m0_rd,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wd,
  output logic [31:0] m1_rd,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWe,
  input  logic [31:0] PrRD,
  output logic        busy
);

  state_e           state_q;
  master_e          owner_q;
  master_e          last_grant_q;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic [31:0]      addr_q;
  logic [31:0]      wd_q;
  logic             pr_we_q;
  logic [31:0]      m0_rd_q;
  logic [31:0]      m1_rd_q;
  logic             m0_ack_q;
  logic             m1_ack_q;
  logic             m0_err_q;
  logic             m1_err_q;

  master_e          grant;
  logic             grant_valid;
  bus_req_t         winner;
  logic             xfer_aligned;

  pr_arb_pick #(
    .RR_MODE  (RR_MODE),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .starve_cnt_i (starve_cnt_q),
    .grant_o      (grant),
    .valid_o      (grant_valid)
  );

  always_comb begin
    if (grant == M1) begin
      winner = '{addr: m1_addr, wd: m1_wd, we: m1_we};
    end else begin
      winner = '{addr: m0_addr, wd: m0_wd, we: m0_we};
    end
  end

  // M1 loses only when it was actually requesting; the count stops at MAX_WAIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant == M1) begin
      starve_cnt_d = '0;
    end else if (m1_req && (starve_cnt_q != CNT_W'(MAX_WAIT))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  assign xfer_aligned = is_aligned(addr_q[1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= M0;
      last_grant_q <= M1;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
      pr_we_q      <= 1'b0;
      m0_rd_q      <= '0;
      m1_rd_q      <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      pr_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (grant_valid) begin
            addr_q       <= winner.addr;
            wd_q         <= winner.wd;
            pr_we_q      <= winner.we & is_aligned(winner.addr[1:0]);
            owner_q      <= grant;
            last_grant_q <= grant;
            starve_cnt_q <= starve_cnt_d;
            state_q      <= ST_XFER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (owner_q == M1) begin
            m1_rd_q  <= xfer_aligned ? PrRD : '0;
            m1_err_q <= ~xfer_aligned;
            m1_ack_q <= 1'b1;
          end else begin
            m0_rd_q  <= xfer_aligned ? PrRD : '0;
            m0_err_q <= ~xfer_aligned;
            m0_ack_q <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PrAddr = addr_q;
  assign PrWD   = wd_q;
  assign PrWe   = pr_we_q;
  assign m0_rd  = m0_rd_q;
  assign m1_rd  = m1_rd_q;
  assign m0_ack = m0_ack_q;
  assign m1_ack = m1_ack_q;
  assign m0_err = m0_err_q;
  assign m1_err = m1_err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin arbiter share stimulus,
// each compared every cycle against a transaction-occupancy reference model.
module tb_pr_bus_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wd = '0, m1_addr = '0, m1_wd = '0;

  logic [31:0] pa[2], pwd[2], prd[2], rd0[2], rd1[2];
  logic        pwe[2], ack0[2], ack1[2], err0[2], err1[2], bsy[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Bridge stand-in: read data is a pure function of the presented address.
  function automatic logic [31:0] bridge_fn(input logic [31:0] a);
    if (a == 32'h0000_7f08) return 32'h0000_1234;
    return {~a[15:0], a[15:0]};
  endfunction

  assign prd[0] = bridge_fn(pa[0]);
  assign prd[1] = bridge_fn(pa[1]);

  pr_bus_arbiter #(.RR_MODE(1'b0), .MAX_WAIT(MAXW), .CNT_W(3)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd),
    .m0_rd(rd0[0]), .m0_ack(ack0[0]), .m0_err(err0[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd),
    .m1_rd(rd1[0]), .m1_ack(ack1[0]), .m1_err(err1[0]),
    .PrAddr(pa[0]), .PrWD(pwd[0]), .PrWe(pwe[0]), .PrRD(prd[0]), .busy(bsy[0])
  );

  pr_bus_arbiter #(.RR_MODE(1'b1), .MAX_WAIT(MAXW), .CNT_W(3)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd),
    .m0_rd(rd0[1]), .m0_ack(ack0[1]), .m0_err(err0[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd),
    .m1_rd(rd1[1]), .m1_ack(ack1[1]), .m1_err(err1[1]),
    .PrAddr(pa[1]), .PrWD(pwd[1]), .PrWe(pwe[1]), .PrRD(prd[1]), .busy(bsy[1])
  );

  // Reference model, index 0 = fixed priority, 1 = round-robin.
  // occ counts cycles the current transaction still occupies the bus (2 = driving, 1 = acking).
  int          occ[2], last_g[2], starve[2], owner[2];
  logic [31:0] l_addr[2], l_wd[2];
  logic        l_we[2];
  logic [31:0] e_rd[2][2];
  logic        e_ack[2][2], e_err[2][2];

  logic        s_r0, s_r1, s_we0, s_we1;
  logic [31:0] s_a0, s_a1, s_wd0, s_wd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int k, input logic r0, input logic r1,
                              input int last, input int st);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (k == 1) return (last == 0) ? 1 : 0;
    return (st == MAXW) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      occ[k] = 0; last_g[k] = 1; starve[k] = 0; owner[k] = 0;
      l_addr[k] = '0; l_wd[k] = '0; l_we[k] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        e_rd[k][m] = '0; e_ack[k][m] = 1'b0; e_err[k][m] = 1'b0;
      end
    end
  endtask

  task automatic model_edge(input int k);
    int nxt;
    int g;
    for (int m = 0; m < 2; m++) begin
      e_ack[k][m] = 1'b0;
      e_err[k][m] = 1'b0;
    end
    nxt = (occ[k] > 0) ? occ[k] - 1 : 0;
    if (occ[k] == 2) begin
      e_ack[k][owner[k]] = 1'b1;
      e_err[k][owner[k]] = (l_addr[k][1:0] != 2'b00);
      e_rd[k][owner[k]]  = (l_addr[k][1:0] == 2'b00) ? bridge_fn(l_addr[k]) : 32'h0;
    end else if (s_r0 || s_r1) begin
      g = pick(k, s_r0, s_r1, last_g[k], starve[k]);
      if (g == 1) starve[k] = 0;
      else if (s_r1 && starve[k] < MAXW) starve[k]++;
      last_g[k] = g;
      owner[k]  = g;
      l_addr[k] = (g == 1) ? s_a1 : s_a0;
      l_wd[k]   = (g == 1) ? s_wd1 : s_wd0;
      l_we[k]   = (g == 1) ? s_we1 : s_we0;
      nxt = 2;
    end
    occ[k] = nxt;
  endtask

  task automatic check_all(input int k);
    check($sformatf("busy[%0d]", k), bsy[k], occ[k] != 0);
    check($sformatf("PrWe[%0d]", k), pwe[k],
          (occ[k] == 2) && l_we[k] && (l_addr[k][1:0] == 2'b00));
    check($sformatf("PrAddr[%0d]", k), pa[k], l_addr[k]);
    check($sformatf("PrWD[%0d]", k), pwd[k], l_wd[k]);
    check($sformatf("m0_ack[%0d]", k), ack0[k], e_ack[k][0]);
    check($sformatf("m1_ack[%0d]", k), ack1[k], e_ack[k][1]);
    check($sformatf("m0_err[%0d]", k), err0[k], e_err[k][0]);
    check($sformatf("m1_err[%0d]", k), err1[k], e_err[k][1]);
    check($sformatf("m0_rd[%0d]", k), rd0[k], e_rd[k][0]);
    check($sformatf("m1_rd[%0d]", k), rd1[k], e_rd[k][1]);
  endtask

  task automatic step();
    s_r0 = m0_req; s_a0 = m0_addr; s_we0 = m0_we; s_wd0 = m0_wd;
    s_r1 = m1_req; s_a1 = m1_addr; s_we1 = m1_we; s_wd1 = m1_wd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      check_all(k);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_all(k);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int got[2][6];
  int ack_at[2][6];
  int got_n[2];
  int exp_fp[6] = '{0, 0, 0, 0, 1, 0};
  int exp_rr[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    #2;
    do_reset();

    // Single M0 read, req dropped while the transfer is on the bus.
    m0_req = 1'b1; m0_addr = 32'h7f08; m0_we = 1'b0;
    step();
    for (int k = 0; k < 2; k++) check($sformatf("rd_praddr[%0d]", k), pa[k], 32'h7f08);
    m0_req = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_ack[%0d]", k), ack0[k], 1'b1);
      check($sformatf("rd_data[%0d]", k), rd0[k], 32'h1234);
      check($sformatf("rd_err[%0d]", k), err0[k], 1'b0);
    end
    step();

    // M1 write.
    m1_req = 1'b1; m1_addr = 32'h7f10; m1_we = 1'b1; m1_wd = 32'hA5;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wr_we[%0d]", k), pwe[k], 1'b1);
      check($sformatf("wr_wd[%0d]", k), pwd[k], 32'hA5);
    end
    m1_req = 1'b0; m1_we = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wr_we_drop[%0d]", k), pwe[k], 1'b0);
      check($sformatf("wr_ack[%0d]", k), ack1[k], 1'b1);
    end
    step();

    // Misaligned write is acked with err and never reaches the bus.
    m0_req = 1'b1; m0_addr = 32'h7f02; m0_we = 1'b1; m0_wd = 32'h55;
    step();
    for (int k = 0; k < 2; k++) check($sformatf("mis_we[%0d]", k), pwe[k], 1'b0);
    m0_req = 1'b0; m0_we = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mis_ack[%0d]", k), ack0[k], 1'b1);
      check($sformatf("mis_err[%0d]", k), err0[k], 1'b1);
      check($sformatf("mis_rd[%0d]", k), rd0[k], 32'h0);
    end
    step();

    // Contention from reset with both requests held.
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h7f00; m1_req = 1'b1; m1_addr = 32'h7f14;
    for (int k = 0; k < 2; k++) begin
      got_n[k] = 0;
      for (int i = 0; i < 6; i++) begin got[k][i] = -1; ack_at[k][i] = -1; end
    end
    for (int c = 0; c < 12; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if ((ack0[k] || ack1[k]) && got_n[k] < 6) begin
          got[k][got_n[k]] = ack1[k] ? 1 : 0;
          ack_at[k][got_n[k]] = c;
          got_n[k]++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("cont_count[%0d]", k), got_n[k], 6);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("cont_grant[%0d][%0d]", k, i), got[k][i],
              (k == 0) ? exp_fp[i] : exp_rr[i]);
        if (i > 0)
          check($sformatf("cont_gap[%0d][%0d]", k, i), ack_at[k][i] - ack_at[k][i-1], 2);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a write transfer.
    m0_req = 1'b1; m0_addr = 32'h7f04; m0_we = 1'b1; m0_wd = 32'hDEAD;
    step();
    for (int k = 0; k < 2; k++) check($sformatf("rst_pre_we[%0d]", k), pwe[k], 1'b1);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_we[%0d]", k), pwe[k], 1'b0);
      check($sformatf("rst_ack0[%0d]", k), ack0[k], 1'b0);
      check($sformatf("rst_ack1[%0d]", k), ack1[k], 1'b0);
      check($sformatf("rst_busy[%0d]", k), bsy[k], 1'b0);
    end
    model_reset();
    @(posedge clk);
    #1;
    m0_req = 1'b0; m0_we = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) step();

    // Randomised traffic across both device windows, some misaligned.
    for (int c = 0; c < 600; c++) begin
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 2) != 0);
      m0_we   = $urandom_range(0, 1) == 1;
      m1_we   = $urandom_range(0, 1) == 1;
      m0_wd   = $urandom;
      m1_wd   = $urandom;
      m0_addr = (($urandom_range(0, 1) == 1) ? 32'h7f10 : 32'h7f00) + 32'($urandom_range(0, 2) * 4)
                + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      m1_addr = (($urandom_range(0, 1) == 1) ? 32'h7f10 : 32'h7f00) + 32'($urandom_range(0, 2) * 4)
                + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
